// File: rtl/gpio_strap_pkg.sv
// gpio_strap_pkg: shared state encoding, default parameters and counter-width helper for strap capture
package gpio_strap_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, DONE, ERR} state_e;

    localparam int WIDTH_DEF  = 32;
    localparam int SETTLE_DEF = 16;
    localparam int NUM_DEF    = 4;
    localparam int GAP_DEF    = 2;
    localparam int RETRY_DEF  = 3;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/gpio_strap_match.sv
// gpio_strap_match: captures the reference strap value and checks later spaced samples against it
module gpio_strap_match
    import gpio_strap_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int NUM_SAMPLES = NUM_DEF,
    parameter int SAMPLE_GAP  = GAP_DEF
) (
    input  logic             PCLK,
    input  logic             clr_i,
    input  logic             sample_en_i,
    input  logic [WIDTH-1:0] gpio_i,
    output logic             match_done_o,
    output logic             mismatch_o,
    output logic [WIDTH-1:0] ref_o
);

    localparam int SW = cnt_w(NUM_SAMPLES);
    localparam int GW = SAMPLE_GAP > 0 ? cnt_w(SAMPLE_GAP) : 1;

    logic [SW-1:0]    smp_q, smp_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             first, take, eq;

    // A sample is taken on the first SAMPLE edge and then whenever the gap counter has run out;
    // on the first sample the live pads are the reference, so a single-sample capture succeeds at once
    always_comb begin
        first        = smp_q == '0;
        take         = sample_en_i && (first || gap_q == '0);
        ref_o        = first ? gpio_i : ref_q;
        eq           = gpio_i == ref_o;
        match_done_o = take && eq && smp_q == SW'(NUM_SAMPLES - 1);
        mismatch_o   = take && !eq;
        smp_d        = smp_q;
        gap_d        = gap_q;
        ref_d        = ref_q;
        if (clr_i) begin
            smp_d = '0;
            gap_d = '0;
            ref_d = '0;
        end else if (take) begin
            smp_d = smp_q + 1'b1;
            gap_d = GW'(SAMPLE_GAP);
            ref_d = ref_o;
        end else if (sample_en_i) begin
            gap_d = gap_q - 1'b1;
        end
    end

    // Sample counters and reference register
    always_ff @(posedge PCLK) begin
        smp_q <= smp_d;
        gap_q <= gap_d;
        ref_q <= ref_d;
    end

endmodule

// File: rtl/gpio_strap_ctrl.sv
// gpio_strap_ctrl: boot-strap capture sequencer (drive, settle, multi-sample agree); GPIO_STRAP_RETRY_EN enables retry on mismatch
module gpio_strap_ctrl
    import gpio_strap_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF,
    parameter int NUM_SAMPLES   = NUM_DEF,
    parameter int SAMPLE_GAP    = GAP_DEF,
    parameter int MAX_RETRY     = RETRY_DEF
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             start_req,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             strap_en,
    output logic             strap_sample_valid,
    output logic [WIDTH-1:0] strap_sample_data,
    output logic             strap_done,
    output logic             strap_err,
    output logic             busy
);

    localparam int TW = cnt_w(SETTLE_CYCLES);

    if (SETTLE_CYCLES < 1 || NUM_SAMPLES < 1 || SAMPLE_GAP < 0 || MAX_RETRY < 0) begin : g_bad_params
        $error("gpio_strap_ctrl: illegal parameter combination");
    end

    state_e           state_q, state_d;
    logic [TW-1:0]    settle_q, settle_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             match_done, mismatch;
    logic [WIDTH-1:0] ref_val;
`ifdef GPIO_STRAP_RETRY_EN
    localparam int RW = MAX_RETRY > 0 ? cnt_w(MAX_RETRY) : 1;
    logic [RW-1:0]    retry_q, retry_d;
`endif

    gpio_strap_match #(
        .WIDTH       (WIDTH),
        .NUM_SAMPLES (NUM_SAMPLES),
        .SAMPLE_GAP  (SAMPLE_GAP)
    ) u_match (
        .PCLK         (PCLK),
        .clr_i        (PRESET || state_q != SAMPLE),
        .sample_en_i  (state_q == SAMPLE),
        .gpio_i       (gpio_in),
        .match_done_o (match_done),
        .mismatch_o   (mismatch),
        .ref_o        (ref_val)
    );

    // Status outputs follow the state directly, so they switch on the same edge as the transition
    always_comb begin
        busy               = state_q == DRIVE || state_q == SAMPLE;
        strap_en           = busy;
        strap_done         = state_q == DONE;
        strap_err          = state_q == ERR;
        strap_sample_valid = valid_q;
        strap_sample_data  = data_q;
    end

    // Next-state logic: settle countdown, sample outcome handling and re-capture requests
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        valid_d  = 1'b0;
        data_d   = data_q;
`ifdef GPIO_STRAP_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            IDLE: begin
                state_d  = DRIVE;
                settle_d = TW'(SETTLE_CYCLES - 1);
            end
            DRIVE: begin
                if (settle_q == '0) state_d = SAMPLE;
                else settle_d = settle_q - 1'b1;
            end
            SAMPLE: begin
                if (match_done) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    data_d  = ref_val;
                end else if (mismatch) begin
`ifdef GPIO_STRAP_RETRY_EN
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d  = retry_q + 1'b1;
                        state_d  = DRIVE;
                        settle_d = TW'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d = ERR;
                    end
`else
                    state_d = ERR;
`endif
                end
            end
            DONE, ERR: begin
                if (start_req) begin
                    state_d  = DRIVE;
                    settle_d = TW'(SETTLE_CYCLES - 1);
`ifdef GPIO_STRAP_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any capture in progress
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            settle_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
`ifdef GPIO_STRAP_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
`ifdef GPIO_STRAP_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_gpio_strap_ctrl.sv
// tb_gpio_strap_ctrl: directed self-checking bench for the strap capture sequencer
module tb_gpio_strap_ctrl;

`ifdef GPIO_STRAP_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        start_req = 1'b0;
    logic [31:0] gpio_in = '0;
    logic        strap_en, strap_sample_valid, strap_done, strap_err, busy;
    logic [31:0] strap_sample_data;
    int          total = 0;
    int          bad = 0;

    always #5 PCLK = ~PCLK;

    gpio_strap_ctrl #(
        .WIDTH         (32),
        .SETTLE_CYCLES (4),
        .NUM_SAMPLES   (3),
        .SAMPLE_GAP    (1),
        .MAX_RETRY     (1)
    ) dut (
        .PCLK               (PCLK),
        .PRESET             (PRESET),
        .start_req          (start_req),
        .gpio_in            (gpio_in),
        .strap_en           (strap_en),
        .strap_sample_valid (strap_sample_valid),
        .strap_sample_data  (strap_sample_data),
        .strap_done         (strap_done),
        .strap_err          (strap_err),
        .busy               (busy)
    );

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".en"}, 32'(strap_en), 0);
        chk({tag, ".valid"}, 32'(strap_sample_valid), 0);
        chk({tag, ".data"}, strap_sample_data, 0);
        chk({tag, ".done"}, 32'(strap_done), 0);
        chk({tag, ".err"}, 32'(strap_err), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    // Edge 1 is the first edge after the caller releases reset or raises start_req.
    // Expect strap_en over edges 1..9, valid pulse at edge 10, and data switching only then.
    task automatic cap(input string tag, input logic [31:0] new_d, input logic [31:0] old_d, input int ign);
        for (int k = 1; k <= 12; k++) begin
            step();
            start_req = (k == ign);
            chk($sformatf("%s.en@%0d", tag, k), 32'(strap_en), 32'(k <= 9));
            chk($sformatf("%s.busy@%0d", tag, k), 32'(busy), 32'(k <= 9));
            chk($sformatf("%s.valid@%0d", tag, k), 32'(strap_sample_valid), 32'(k == 10));
            chk($sformatf("%s.data@%0d", tag, k), strap_sample_data, k >= 10 ? new_d : old_d);
            chk($sformatf("%s.done@%0d", tag, k), 32'(strap_done), 32'(k >= 10));
            chk($sformatf("%s.err@%0d", tag, k), 32'(strap_err), 0);
        end
    endtask

    initial begin
        gpio_in = 32'hA5A5_0F0F;
        step();
        step();
        chk_zero("reset");
        PRESET = 1'b0;
        cap("stable", 32'hA5A5_0F0F, 32'h0, 0);

        gpio_in   = 32'h1234_5678;
        start_req = 1'b1;
        cap("ignreq", 32'h1234_5678, 32'hA5A5_0F0F, 3);

        gpio_in   = 32'hDEAD_BEEF;
        start_req = 1'b1;
        cap("recap", 32'hDEAD_BEEF, 32'h1234_5678, 0);

        start_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            gpio_in = (k == 8) ? 32'hA5A5_0F0E : 32'hA5A5_0F0F;
            step();
            start_req = 1'b0;
            chk($sformatf("glitch.en@%0d", k), 32'(strap_en), 32'(k <= (RETRY ? 16 : 7)));
            chk($sformatf("glitch.valid@%0d", k), 32'(strap_sample_valid), 32'(RETRY && k == 17));
            chk($sformatf("glitch.err@%0d", k), 32'(strap_err), 32'(!RETRY && k >= 8));
            chk($sformatf("glitch.done@%0d", k), 32'(strap_done), 32'(RETRY && k >= 17));
            chk($sformatf("glitch.data@%0d", k), strap_sample_data,
                (RETRY && k >= 17) ? 32'hA5A5_0F0F : 32'hDEAD_BEEF);
        end

        gpio_in   = 32'hA5A5_0F0F;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        chk("midrst.started", 32'(strap_en), 1);
        for (int k = 2; k <= 7; k++) step();
        PRESET = 1'b1;
        step();
        chk_zero("midrst");
        PRESET = 1'b0;
        cap("afterrst", 32'hA5A5_0F0F, 32'h0, 0);

        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            gpio_in = 32'h100 + 32'(k);
            step();
            chk($sformatf("noisy.en@%0d", k), 32'(strap_en), 32'(k < (RETRY ? 15 : 8)));
            chk($sformatf("noisy.valid@%0d", k), 32'(strap_sample_valid), 0);
            chk($sformatf("noisy.err@%0d", k), 32'(strap_err), 32'(k >= (RETRY ? 15 : 8)));
            chk($sformatf("noisy.done@%0d", k), 32'(strap_done), 0);
            chk($sformatf("noisy.data@%0d", k), strap_sample_data, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
